wb_stage: RTL and testbench

- Writeback stage directly upstream of the 16-entry register file.
- Accepts retiring instructions (ALU result or load) and waits for load data from data memory.
- Extracts bytes for LDRB (big-endian, byte 0 = bits [31:24], matching the register file's byte order).
- Drives the register file write port (we/wa/wd) and stalls upstream while a load is outstanding.

---
 rtl/wb_stage_if.sv | 39 +++
 rtl/wb_stage.sv | 96 +++++++++
 tb/tb_wb_stage.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/wb_stage_if.sv
// wb_stage_if: retire, load-data and register-file write signals of the writeback stage.
// The byp_* bypass signals exist only when WB_BYPASS_EN is defined.
`ifndef FULLW
`define FULLW 32
`endif
interface wb_stage_if #(parameter int ADDR_WIDTH = 4);
    logic                  in_valid;
    logic                  in_we;
    logic                  in_is_load;
    logic                  in_is_byte;
    logic [1:0]            in_byte_sel;
    logic [ADDR_WIDTH-1:0] in_wa;
    logic [`FULLW-1:0]     in_alu;
    logic                  mem_rvalid;
    logic [`FULLW-1:0]     mem_rdata;
    logic                  stall;
    logic                  rf_we;
    logic [ADDR_WIDTH-1:0] rf_wa;
    logic [`FULLW-1:0]     rf_wd;
    logic                  err;
`ifdef WB_BYPASS_EN
    logic                  byp_valid;
    logic [ADDR_WIDTH-1:0] byp_wa;
    logic [`FULLW-1:0]     byp_wd;
    modport master(output in_valid, in_we, in_is_load, in_is_byte, in_byte_sel, in_wa, in_alu,
                   mem_rvalid, mem_rdata,
                   input stall, rf_we, rf_wa, rf_wd, err, byp_valid, byp_wa, byp_wd);
    modport slave(input in_valid, in_we, in_is_load, in_is_byte, in_byte_sel, in_wa, in_alu,
                  mem_rvalid, mem_rdata,
                  output stall, rf_we, rf_wa, rf_wd, err, byp_valid, byp_wa, byp_wd);
`else
    modport master(output in_valid, in_we, in_is_load, in_is_byte, in_byte_sel, in_wa, in_alu,
                   mem_rvalid, mem_rdata,
                   input stall, rf_we, rf_wa, rf_wd, err);
    modport slave(input in_valid, in_we, in_is_load, in_is_byte, in_byte_sel, in_wa, in_alu,
                  mem_rvalid, mem_rdata,
                  output stall, rf_we, rf_wa, rf_wd, err);
`endif
endinterface

// File: rtl/wb_stage.sv
// wb_stage: writeback stage feeding the register file; waits for load data, extracts LDRB bytes.
// Optional WB_BYPASS_EN adds a one-cycle-delayed copy of the write port for read bypassing.
`ifndef FULLW
`define FULLW 32
`endif
module wb_stage #(
    parameter int ADDR_WIDTH   = 4,
    parameter int LOAD_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    wb_stage_if.slave   bus
);
    localparam int CW = $clog2(LOAD_TIMEOUT) + 1;
    typedef enum logic {IDLE, WAIT_LOAD} state_t;
    state_t                r_state;
    logic [CW-1:0]         r_cnt;
    logic                  r_we_q;
    logic                  r_err;
    logic                  r_ld_we;
    logic                  r_ld_byte;
    logic [1:0]            r_ld_sel;
    logic [ADDR_WIDTH-1:0] r_ld_wa;
    logic [ADDR_WIDTH-1:0] r_wa;
    logic [`FULLW-1:0]     r_wd;
    logic [7:0]            w_byte;
    logic [`FULLW-1:0]     w_ld_data;
    // Big-endian byte order: sel 0 is the most significant byte
    assign w_byte    = bus.mem_rdata[{~r_ld_sel, 3'b000} +: 8];
    assign w_ld_data = r_ld_byte ? {{(`FULLW-8){1'b0}}, w_byte} : bus.mem_rdata;
    assign bus.stall = (r_state == WAIT_LOAD);
    assign bus.rf_we = r_we_q & en;
    assign bus.rf_wa = r_wa;
    assign bus.rf_wd = r_wd;
    assign bus.err   = r_err;
`ifdef WB_BYPASS_EN
    logic                  r_byp_valid;
    logic [ADDR_WIDTH-1:0] r_byp_wa;
    logic [`FULLW-1:0]     r_byp_wd;
    assign bus.byp_valid = r_byp_valid;
    assign bus.byp_wa    = r_byp_wa;
    assign bus.byp_wd    = r_byp_wd;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_byp_valid <= 1'b0;
            r_byp_wa    <= '0;
            r_byp_wd    <= '0;
        end else if (en) begin
            r_byp_valid <= r_we_q;
            r_byp_wa    <= r_wa;
            r_byp_wd    <= r_wd;
        end
    end
`endif
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_we_q    <= 1'b0;
            r_err     <= 1'b0;
            r_ld_we   <= 1'b0;
            r_ld_byte <= 1'b0;
            r_ld_sel  <= '0;
            r_ld_wa   <= '0;
            r_wa      <= '0;
            r_wd      <= '0;
        end else if (en) begin
            r_we_q <= 1'b0;
            if (r_state == IDLE) begin
                if (bus.in_valid && bus.in_is_load) begin
                    r_state   <= WAIT_LOAD;
                    r_cnt     <= '0;
                    r_ld_we   <= bus.in_we;
                    r_ld_byte <= bus.in_is_byte;
                    r_ld_sel  <= bus.in_byte_sel;
                    r_ld_wa   <= bus.in_wa;
                end else if (bus.in_valid && bus.in_we) begin
                    r_we_q <= 1'b1;
                    r_wa   <= bus.in_wa;
                    r_wd   <= bus.in_alu;
                end
            end else if (bus.mem_rvalid) begin
                r_state <= IDLE;
                r_we_q  <= r_ld_we;
                r_wa    <= r_ld_wa;
                r_wd    <= w_ld_data;
            end else if (r_cnt == CW'(LOAD_TIMEOUT - 1)) begin
                r_state <= IDLE;
                r_err   <= 1'b1;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: randomized scoreboard bench for wb_stage; expected writes are queued with
// the enabled-cycle count at which they must appear on the register file port.
`ifndef FULLW
`define FULLW 32
`endif
module tb_wb_stage;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic en = 1'b0;
    wb_stage_if #(.ADDR_WIDTH(4)) bus();
    wb_stage #(.ADDR_WIDTH(4), .LOAD_TIMEOUT(15)) dut(.clk(clk), .reset(reset), .en(en), .bus(bus));
    always #5 clk = ~clk;

    typedef struct {logic [3:0] wa; logic [31:0] wd; int tag;} wr_t;
    wr_t sb[$];
    wr_t e;
    int tests = 0;
    int fails = 0;
    int ecnt = 0;
    bit exp_err = 1'b0;
    bit rnd_en = 1'b0;
    bit eb_v = 1'b0;
    logic [3:0] eb_wa;
    logic [31:0] eb_wd;

    always @(posedge clk) if (en) ecnt <= ecnt + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] extract(input logic [31:0] w, input bit by, input int sel);
        return by ? {24'd0, w[8*(3-sel) +: 8]} : w;
    endfunction

    // Monitor: every rf_we pulse must match the oldest expected write, at the right cycle
    always @(negedge clk) begin
        if (!reset) begin
            eb_v = 1'b0;
        end else begin
`ifdef WB_BYPASS_EN
            chk("byp_valid", bus.byp_valid, eb_v);
            if (eb_v) begin
                chk("byp_wa", bus.byp_wa, eb_wa);
                chk("byp_wd", bus.byp_wd, eb_wd);
            end
`endif
            if (bus.rf_we) begin
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL spurious_rf_we: got write wa=%0h wd=%0h, expected no write", bus.rf_wa, bus.rf_wd);
                end else begin
                    e = sb.pop_front();
                    chk("rf_wa", bus.rf_wa, e.wa);
                    chk("rf_wd", bus.rf_wd, e.wd);
                    chk("write_latency", ecnt, e.tag);
                    eb_wa = e.wa;
                    eb_wd = e.wd;
                end
            end
            if (en) eb_v = bus.rf_we;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input logic v, we, ld, by, input logic [1:0] sel, input logic [3:0] wa,
                       input logic [31:0] alu, input logic rv, input logic [31:0] rd);
        while (rnd_en && $urandom_range(0, 7) == 0) begin
            en = 1'b0;
            bus.in_valid = 1'($urandom);
            bus.in_we = 1'($urandom);
            bus.in_is_load = 1'($urandom);
            bus.in_is_byte = 1'($urandom);
            bus.in_byte_sel = 2'($urandom);
            bus.in_wa = 4'($urandom);
            bus.in_alu = $urandom;
            bus.mem_rvalid = 1'($urandom);
            bus.mem_rdata = $urandom;
            tick();
            chk("rf_we_frozen", bus.rf_we, 1'b0);
        end
        en = 1'b1;
        bus.in_valid = v;
        bus.in_we = we;
        bus.in_is_load = ld;
        bus.in_is_byte = by;
        bus.in_byte_sel = sel;
        bus.in_wa = wa;
        bus.in_alu = alu;
        bus.mem_rvalid = rv;
        bus.mem_rdata = rd;
        tick();
    endtask

    task automatic alu_op(input bit v, input bit we, input logic [3:0] wa, input logic [31:0] d);
        cyc(v, we, 1'b0, 1'($urandom), 2'($urandom), wa, d, 1'($urandom), $urandom);
        if (v && we) sb.push_back('{wa, d, ecnt});
        chk("stall_alu", bus.stall, 1'b0);
        chk("err_alu", bus.err, exp_err);
    endtask

    // k = enabled wait cycles until data arrives; k > 15 means data never arrives
    task automatic load_op(input bit we, input bit by, input int sel, input logic [3:0] wa,
                           input int k, input logic [31:0] d);
        cyc(1'b1, we, 1'b1, by, 2'(sel), wa, $urandom, 1'($urandom), $urandom);
        for (int i = 1; i <= (k > 15 ? 15 : k); i++) begin
            chk("stall_wait", bus.stall, 1'b1);
            cyc(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 2'($urandom), 4'($urandom),
                $urandom, (i == k), (i == k) ? d : $urandom);
        end
        if (k > 15) exp_err = 1'b1;
        else if (we) sb.push_back('{wa, extract(d, by, sel), ecnt});
        chk("stall_done", bus.stall, 1'b0);
        chk("err_load", bus.err, exp_err);
    endtask

    initial begin
        bus.in_valid = 0; bus.in_we = 0; bus.in_is_load = 0; bus.in_is_byte = 0;
        bus.in_byte_sel = 0; bus.in_wa = 0; bus.in_alu = 0; bus.mem_rvalid = 0; bus.mem_rdata = 0;
        repeat (2) tick();
        chk("rst_rf_we", bus.rf_we, 1'b0);
        chk("rst_rf_wa", bus.rf_wa, 4'd0);
        chk("rst_rf_wd", bus.rf_wd, 32'd0);
        chk("rst_err", bus.err, 1'b0);
        chk("rst_stall", bus.stall, 1'b0);
        reset = 1'b1;
        tick();
        alu_op(1, 1, 4'd3, 32'h12345678);
        alu_op(0, 0, 4'd0, 32'd0);
        load_op(1, 0, 0, 4'd5, 3, 32'hCAFEF00D);
        load_op(1, 1, 2, 4'd7, 2, 32'hAABBCCDD);
        load_op(1, 1, 0, 4'd8, 1, 32'hAABBCCDD);
        alu_op(1, 0, 4'd9, 32'hDEADBEEF);
        load_op(1, 0, 0, 4'd6, 15, 32'h0BADF00D);
        alu_op(1, 1, 4'd9, 32'h55AA55AA);
        repeat (2) begin
            en = 1'b0;
            tick();
            chk("rf_we_en0", bus.rf_we, 1'b0);
        end
        alu_op(1, 1, 4'd10, 32'h00000001);
        load_op(1, 0, 0, 4'd4, 16, 32'd0);
        alu_op(1, 1, 4'd11, 32'h13579BDF);
        rnd_en = 1'b1;
        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(0, 3))
                0, 1: alu_op(1, $urandom_range(0, 3) != 0, 4'($urandom), $urandom);
                2: alu_op(0, 1'($urandom), 4'($urandom), $urandom);
                default: load_op($urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 3),
                                 4'($urandom), $urandom_range(1, 16), $urandom);
            endcase
        end
        rnd_en = 1'b0;
        alu_op(0, 0, 4'd0, 32'd0);
        alu_op(0, 0, 4'd0, 32'd0);
        cyc(1, 1, 1, 0, 0, 4'd12, 32'd0, 0, 32'd0);
        cyc(0, 0, 0, 0, 0, 4'd0, 32'd0, 0, 32'd0);
        chk("stall_pre_rst", bus.stall, 1'b1);
        reset = 1'b0;
        #2;
        exp_err = 1'b0;
        chk("midrst_stall", bus.stall, 1'b0);
        chk("midrst_err", bus.err, 1'b0);
        chk("midrst_rf_we", bus.rf_we, 1'b0);
        chk("midrst_rf_wa", bus.rf_wa, 4'd0);
        chk("midrst_rf_wd", bus.rf_wd, 32'd0);
        tick();
        reset = 1'b1;
        cyc(0, 0, 0, 0, 0, 4'd0, 32'd0, 1, 32'hFFFFFFFF);
        alu_op(0, 0, 4'd0, 32'd0);
        alu_op(1, 1, 4'd2, 32'hA5A5A5A5);
        alu_op(0, 0, 4'd0, 32'd0);
        alu_op(0, 0, 4'd0, 32'd0);
        chk("sb_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
